// File: rtl/alu_arbiter.sv
// Round-robin owner of the shared 32-bit ALU: holds operands for the op latency,
// captures result and flags, and returns them to the owner over valid/ready.
module alu_arbiter #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter logic [3:0]  OP_MUL     = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [3:0]  req_op_0,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [3:0]  req_op_1,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    output logic        resp_valid_0,
    input  logic        resp_ready_0,
    output logic        resp_valid_1,
    input  logic        resp_ready_1,
    output logic [31:0] resp_result,
    output logic        resp_over,
    output logic        resp_under,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_over,
    input  logic        alu_under,
    output logic        busy,
    output logic [15:0] ops_done
);
    // state | meaning
    // IDLE  | no operation owned; grant to a valid requester is combinational
    // EXEC  | operands held on the ALU, counting down the op latency
    // RESP  | result captured, waiting for the owner's resp_ready
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        rr_ptr;
    logic        owner;
    logic [3:0]  cnt;
    logic        grant_0, grant_1;
    logic        accept, retire, accept_id;
    logic [3:0]  acc_op;
    logic [31:0] acc_a, acc_b;
    logic [3:0]  acc_cnt;

    assign grant_0 = req_valid_0 && (!req_valid_1 || !rr_ptr);
    assign grant_1 = req_valid_1 && (!req_valid_0 ||  rr_ptr);

    assign req_ready_0 = (state == IDLE) && grant_0;
    assign req_ready_1 = (state == IDLE) && grant_1;

    // A ready is only ever raised for a valid requester, so ready alone means accept.
    assign accept    = req_ready_0 || req_ready_1;
    assign accept_id = req_ready_1;
    assign acc_op    = accept_id ? req_op_1 : req_op_0;
    assign acc_a     = accept_id ? req_a_1  : req_a_0;
    assign acc_b     = accept_id ? req_b_1  : req_b_0;
    assign acc_cnt   = (acc_op == OP_MUL) ? 4'(MUL_CYCLES - 1) : 4'd0;

    assign retire       = (state == RESP) && (owner ? resp_ready_1 : resp_ready_0);
    assign resp_valid_0 = (state == RESP) && !owner;
    assign resp_valid_1 = (state == RESP) &&  owner;
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)       state_nxt = EXEC;
            EXEC:    if (cnt == 4'd0)  state_nxt = RESP;
            RESP:    if (retire)       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            cnt         <= 4'd0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_sel     <= 4'd0;
            resp_result <= 32'd0;
            resp_over   <= 1'b0;
            resp_under  <= 1'b0;
            ops_done    <= 16'd0;
        end else begin
            if (accept) begin
                alu_sel <= acc_op;
                alu_a   <= acc_a;
                alu_b   <= acc_b;
                owner   <= accept_id;
                cnt     <= acc_cnt;
            end
            if (state == EXEC) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    resp_result <= alu_out;
                    resp_over   <= alu_over;
                    resp_under  <= alu_under;
                end
            end
            // Pointer moves only on retire so a lone requester can issue back-to-back.
            if (retire) begin
                rr_ptr   <= ~owner;
                ops_done <= ops_done + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to alu_*.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [3:0]  req_op_0 = 4'd0, req_op_1 = 4'd0;
    logic [31:0] req_a_0 = 32'd0, req_b_0 = 32'd0, req_a_1 = 32'd0, req_b_1 = 32'd0;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;
    logic [31:0] resp_result;
    logic        resp_over, resp_under;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_over, alu_under;
    logic        busy;
    logic [15:0] ops_done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_ops = 16'd0;

    alu_arbiter #(.MUL_CYCLES(2), .OP_MUL(OP_MUL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1),
        .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
        .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_result(resp_result), .resp_over(resp_over), .resp_under(resp_under),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_over(alu_over), .alu_under(alu_under),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    logic [31:0] sum, diff;
    logic [63:0] prod;
    always_comb begin
        sum       = alu_a + alu_b;
        diff      = alu_a - alu_b;
        prod      = 64'(alu_a) * 64'(alu_b);
        alu_out   = 32'hDEAD_BEEF;
        alu_over  = 1'b0;
        alu_under = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                alu_out   = sum;
                alu_over  = !alu_a[31] && !alu_b[31] &&  sum[31];
                alu_under =  alu_a[31] &&  alu_b[31] && !sum[31];
            end
            OP_SUB: begin
                alu_out   = diff;
                alu_over  = !alu_a[31] &&  alu_b[31] &&  diff[31];
                alu_under =  alu_a[31] && !alu_b[31] && !diff[31];
            end
            OP_MUL: begin
                alu_out  = prod[31:0];
                alu_over = (prod[63:32] != 32'd0);
            end
            OP_XOR:  alu_out = alu_a ^ alu_b;
            default: ;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req_valid_0 = 1'b1; req_op_0 = op; req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = 1'b1; req_op_1 = op; req_a_1 = a; req_b_1 = b;
        end
    endtask

    task automatic withdraw(input int id);
        if (id == 0) req_valid_0 = 1'b0;
        else         req_valid_1 = 1'b0;
    endtask

    function automatic logic ready_of(input int id);
        return (id == 0) ? req_ready_0 : req_ready_1;
    endfunction

    function automatic logic valid_of(input int id);
        return (id == 0) ? resp_valid_0 : resp_valid_1;
    endfunction

    // Issues one op with resp_ready held high and checks latency, payload and retire.
    task automatic run_op(input string tag, input int id, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ov,
                          input logic exp_un, input int exp_lat);
        int n;
        present(id, op, a, b);
        if (id == 0) resp_ready_0 = 1'b1; else resp_ready_1 = 1'b1;
        #1;
        n = 0;
        while (!ready_of(id) && n < 50) begin tick(); n++; end
        check_val({tag, " req_ready"}, 32'(ready_of(id)), 32'd1);
        tick();
        withdraw(id);
        check_val({tag, " alu_sel"}, 32'(alu_sel), 32'(op));
        check_val({tag, " alu_a"}, alu_a, a);
        n = 0;
        while (!valid_of(id) && n < 40) begin tick(); n++; end
        check_val({tag, " latency"}, 32'(n), 32'(exp_lat));
        check_val({tag, " result"}, resp_result, exp_res);
        check_val({tag, " over"}, 32'(resp_over), 32'(exp_ov));
        check_val({tag, " under"}, 32'(resp_under), 32'(exp_un));
        tick();
        exp_ops = exp_ops + 16'd1;
        check_val({tag, " ops_done"}, 32'(ops_done), 32'(exp_ops));
        check_val({tag, " busy after retire"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #3;
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst resp_valid_0", 32'(resp_valid_0), 32'd0);
        check_val("rst resp_valid_1", 32'(resp_valid_1), 32'd0);
        check_val("rst ops_done", 32'(ops_done), 32'd0);
        check_val("rst alu_a", alu_a, 32'd0);
        check_val("rst req_ready_0 idle", 32'(req_ready_0), 32'd0);

        // Both requesters valid from reset: req0 first, then strict alternation.
        present(0, OP_SUB, 32'd5, 32'd3);
        present(1, OP_XOR, 32'hAAAA_AAAA, 32'h5555_5555);
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rr1 ready_0", 32'(req_ready_0), 32'd1);
        check_val("rr1 ready_1", 32'(req_ready_1), 32'd0);
        tick();
        withdraw(0);
        tick();
        check_val("rr1 resp_valid_0", 32'(resp_valid_0), 32'd1);
        check_val("rr1 resp_valid_1", 32'(resp_valid_1), 32'd0);
        check_val("rr1 result", resp_result, 32'd2);
        check_val("rr1 ready_1 in resp", 32'(req_ready_1), 32'd0);
        tick();
        present(0, OP_ADD, 32'd10, 32'd20);
        #1;
        check_val("rr2 ready_1", 32'(req_ready_1), 32'd1);
        check_val("rr2 ready_0", 32'(req_ready_0), 32'd0);
        tick();
        withdraw(1);
        tick();
        check_val("rr2 resp_valid_1", 32'(resp_valid_1), 32'd1);
        check_val("rr2 resp_valid_0", 32'(resp_valid_0), 32'd0);
        check_val("rr2 result", resp_result, 32'hFFFF_FFFF);
        present(1, OP_ADD, 32'd100, 32'd200);
        tick();
        check_val("rr3 ready_0", 32'(req_ready_0), 32'd1);
        check_val("rr3 ready_1", 32'(req_ready_1), 32'd0);
        tick();
        withdraw(0);
        tick();
        check_val("rr3 result", resp_result, 32'd30);
        tick();
        check_val("rr4 ready_1", 32'(req_ready_1), 32'd1);
        tick();
        withdraw(1);
        tick();
        check_val("rr4 resp_valid_1", 32'(resp_valid_1), 32'd1);
        check_val("rr4 result", resp_result, 32'd300);
        tick();
        exp_ops = 16'd4;
        check_val("rr ops_done", 32'(ops_done), 32'(exp_ops));

        run_op("add 1+2", 0, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);
        run_op("mul 3*7", 1, OP_MUL, 32'd3, 32'd7, 32'd21, 1'b0, 1'b0, 2);
        run_op("add ovf", 0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0, 1);
        run_op("sub unf", 1, OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
        run_op("unknown op", 1, 4'hF, 32'd9, 32'd9, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);

        // Backpressure on req0 while req1 waits.
        present(0, OP_ADD, 32'd7, 32'd8);
        resp_ready_0 = 1'b0;
        #1;
        tick();
        withdraw(0);
        present(1, OP_ADD, 32'd1, 32'd1);
        resp_ready_1 = 1'b1;
        tick();
        check_val("bp resp_valid_0", 32'(resp_valid_0), 32'd1);
        check_val("bp result", resp_result, 32'd15);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp hold resp_valid_0", 32'(resp_valid_0), 32'd1);
            check_val("bp hold result", resp_result, 32'd15);
            check_val("bp hold ready_1", 32'(req_ready_1), 32'd0);
            check_val("bp hold busy", 32'(busy), 32'd1);
        end
        resp_ready_0 = 1'b1;
        tick();
        exp_ops = exp_ops + 16'd1;
        check_val("bp ops_done", 32'(ops_done), 32'(exp_ops));
        check_val("bp ready_1 after retire", 32'(req_ready_1), 32'd1);
        tick();
        withdraw(1);
        check_val("bp req1 accepted", 32'(alu_a), 32'd1);
        tick();
        check_val("bp req1 resp_valid", 32'(resp_valid_1), 32'd1);
        check_val("bp req1 result", resp_result, 32'd2);
        tick();
        exp_ops = exp_ops + 16'd1;

        // Reset pulse during a MUL in EXEC drops the op.
        present(1, OP_MUL, 32'd6, 32'd9);
        #1;
        tick();
        withdraw(1);
        check_val("rst-mid busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check_val("rst-mid busy", 32'(busy), 32'd0);
        check_val("rst-mid alu_a", alu_a, 32'd0);
        check_val("rst-mid alu_b", alu_b, 32'd0);
        check_val("rst-mid alu_sel", 32'(alu_sel), 32'd0);
        check_val("rst-mid ops_done", 32'(ops_done), 32'd0);
        rst_n = 1'b1;
        exp_ops = 16'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rst-mid no resp", 32'(resp_valid_1), 32'd0);
        end
        run_op("add after rst", 0, OP_ADD, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0, 1);

        // Preload the retire counter near the top to exercise its wrap.
        force dut.ops_done = 16'hFFFE;
        #1;
        release dut.ops_done;
        exp_ops = 16'hFFFE;
        check_val("wrap preload", 32'(ops_done), 32'h0000_FFFE);
        run_op("wrap to ffff", 0, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);
        run_op("wrap to 0", 1, OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);
        check_val("wrap zero", 32'(ops_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (ADD/SUB/MUL/AND/OR/XOR/NOT/EQ/NEQ/LT/LTE/GT/GTE, encodings per `opcodes.vh`). It grants the ALU to one requester at a time using round-robin priority and holds the operands in registers for the op's latency. MUL gets a configurable multicycle settle window. It then captures the result and overflow/underflow flags and returns them to the owner over a valid/ready response channel. It sits between the ALU and its two clients, typically the decode/execute front-ends.

## Interface
- MUL_CYCLES, 2: cycles operands are held before capture for `MUL`; legal 1–15. All other opcodes use 1.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_k (k=0,1)  in  1  requester k presents an operation.
- req_ready_k (k=0,1)  out  1  arbiter accepts requester k this cycle.
- req_op_k  in  4  opcode for requester k.
- req_a_k, req_b_k  in  32  operands for requester k.
- resp_valid_k  out  1  result available for requester k.
- resp_ready_k  in  1  requester k consumes the result.
- resp_result  out  32  registered ALU result, shared by both requesters and qualified by resp_valid_k.
- resp_over, resp_under  out  1  registered ALU overflow/underflow flags.
- alu_a, alu_b  out  32  registered operands driven to the ALU `input1`/`input2`.
- alu_sel  out  4  registered opcode driven to the ALU `alu_sel`.
- alu_out  in  32  ALU result.
- alu_over, alu_under  in  1  ALU flags.
- busy  out  1  high when the FSM is in EXEC or RESP.
- ops_done  out  16  count of retired operations; wraps modulo 2^16.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE.** Grant is combinational:
  - If only one req_valid_k is high, that requester wins.
  - If both are high, the requester selected by `rr_ptr` wins.
  - req_ready_k = (state==IDLE) && grant_k. With no valid request, both readies are 0.
- **Accept** happens on req_valid_k && req_ready_k. On that edge:
  - latch op/a/b into alu_sel/alu_a/alu_b;
  - latch the owner id;
  - load cnt = (op==MUL ? MUL_CYCLES : 1) − 1;
  - go to EXEC.
- **EXEC.** The ALU inputs stay constant.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture alu_out/alu_over/alu_under into resp_result/resp_over/resp_under and go to RESP.
- **RESP.** resp_valid_owner = 1; the other requester's resp_valid stays 0.
  - On resp_ready_owner: go to IDLE, set rr_ptr = ~owner, and increment ops_done.
  - resp_result and the flags hold until the next capture.
- Unrecognised opcodes are not filtered. They use latency 1 and return whatever the ALU produces.
- No new request is accepted outside IDLE; requesters hold req_valid and the payload until accepted.
- `rr_ptr` only changes on retire, so a lone requester may issue back-to-back.
- Reset (async, any state): state=IDLE, rr_ptr=0, cnt=0, and alu_a/alu_b/alu_sel/resp_result/resp_over/resp_under/ops_done = 0. An in-flight operation is dropped and no response is issued.
- Reset values of the outputs: busy=0, resp_valid_k=0. req_ready_k is 0 unless a valid request is present after reset deasserts.

## Timing
- With accept at edge 0 and L = op latency:
  - the ALU sees the new operands from edge 0;
  - results are captured at edge L;
  - resp_valid is high from edge L.
- With resp_ready held high, retire happens at edge L+1, and the next accept can occur at edge L+2.
- Peak throughput is therefore one op per L+2 cycles (3 for non-MUL, 4 for MUL with MUL_CYCLES=2).
- req_ready is combinational from req_valid and the state; all other outputs are registered.
- With both requesters valid continuously, grants alternate strictly 0,1,0,1,...
- Backpressure: while resp_ready_owner=0, resp_valid, resp_result, the flags and busy hold unchanged, and no req_ready is asserted.

## Test plan
- ADD, req0 (a=1, b=2), resp_ready=1 → resp_valid_0 at edge 1, resp_result=3, over=0, under=0, ops_done=1.
- MUL, req1 (a=3, b=7), MUL_CYCLES=2 → resp_valid_1 at edge 2, resp_result=21. ADD overflow (0x7FFFFFFF + 1) → resp_result=0x80000000, over=1.
- Both requesters valid from reset (req0 SUB 5−3, req1 XOR 0xAAAAAAAA^0x55555555) → req0 served first with result 2, then req1 with result 0xFFFFFFFF; a third simultaneous pair again serves req0 first.
- resp_ready_0 held low 5 cycles while req1 is valid → resp_valid_0 and resp_result stay stable, req_ready_1 stays 0, and req1 is accepted the cycle after retire.
- rst_n pulsed low mid-EXEC of a MUL → no resp_valid, busy=0, alu_* = 0; the next ADD completes normally.
- 65536 retired ops → ops_done wraps from 0xFFFF to 0x0000.
